// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the M stage of the pipelined ARM core.
// It models WAIT_STATES stall cycles per access. While an access is outstanding it
// holds the pipeline-advance signal Enable low.
//
// Optional feature: define DMEM_STATS_EN to add saturating access counters.
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   reset       synchronous, active-high reset
//   MemReadM    read request from the M stage
//   MemWriteM   write request from the M stage (read+write is treated as a write)
//   ALUOutM     byte address; bits [1:0] ignored (word access)
//   WriteDataM  store data
//   ReadDataM   load data, valid only in the completion cycle
//   Enable      pipeline advance (0 = core stalled)
//   Busy        FSM not in IDLE
//   AddrErr     one-cycle pulse in the completion cycle of an out-of-range access
//   ReadCnt     (DMEM_STATS_EN) completed reads, saturating
//   WriteCnt    (DMEM_STATS_EN) completed writes, saturating
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        Enable,
  output logic        Busy,
  output logic        AddrErr
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] ReadCnt,
  output logic [15:0] WriteCnt
`endif
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam bit          ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0]  WS_LOAD   = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [31:0]   mem [DEPTH];

  logic          req;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          complete;
  logic          commit;
  logic          unused_addr_lsbs;

  assign req              = MemReadM | MemWriteM;
  assign idx              = ALUOutM[AW+1:2];
  assign in_range         = (ALUOutM[31:AW+2] == '0);
  assign unused_addr_lsbs = ^ALUOutM[1:0];

  // Completion is the DONE cycle, or the request cycle itself in a zero-wait build.
  assign complete = (state == DONE) || (ZERO_WAIT && (state == IDLE) && req);
  assign commit   = complete && MemWriteM && in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req && !ZERO_WAIT) begin
            cnt   <= WS_LOAD;
            state <= (WAIT_STATES == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          // Inputs are held by the stalled core, so nothing is re-sampled here.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage: cleared on reset; a write pending when reset hits never reaches commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[idx] <= WriteDataM;
    end
  end

  always_comb begin
    Enable = 1'b1;
    unique case (state)
      IDLE:    Enable = !(req && !ZERO_WAIT);
      WAIT:    Enable = 1'b0;
      DONE:    Enable = 1'b1;
      default: Enable = 1'b1;
    endcase
  end

  assign Busy    = (state != IDLE);
  assign AddrErr = complete && !in_range;
  // Combinational read returns the pre-write word when read and write coincide.
  assign ReadDataM = (complete && MemReadM && in_range) ? mem[idx] : '0;

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ReadCnt  <= '0;
      WriteCnt <= '0;
    end else if (complete) begin
      if (MemWriteM) begin
        if (WriteCnt != 16'hFFFF) WriteCnt <= WriteCnt + 16'd1;
      end else begin
        if (ReadCnt != 16'hFFFF) ReadCnt <= ReadCnt + 16'd1;
      end
    end
  end
`endif

endmodule
